// File: rtl/noc_pkg.sv
// Shared router constants: port codes, crossbar select encoding, allocator state.
package noc_pkg;

  localparam int N_PORTS = 5;
  localparam int SEL_W   = 3;

  localparam logic [2:0] PORT_L   = 3'd0;
  localparam logic [2:0] PORT_N   = 3'd1;
  localparam logic [2:0] PORT_E   = 3'd2;
  localparam logic [2:0] PORT_S   = 3'd3;
  localparam logic [2:0] PORT_W   = 3'd4;
  localparam logic [2:0] SEL_IDLE = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // Port index + 1, wrapping 4 -> 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 5-way round-robin pick: first set request scanning from ptr upward, mod 5.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       any_gnt
);

  // Padded so any 3-bit index is in range; upper bits never request.
  logic [7:0] req_x;
  logic [2:0] idx;

  assign req_x = {3'b000, req};

  // Walk the five candidates in priority order, keep the first hit.
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = ptr;
    for (int k = 0; k < 5; k++) begin
      if (!any_gnt && req_x[idx]) begin
        gnt_idx = idx;
        any_gnt = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator for the 5-port crossbar: per-output round-robin arbitration,
// wormhole lock from head to tail, crossbar select codes and per-input grants.
module switch_allocator #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PORTS-1:0]   in_valid,
  input  logic [3*N_PORTS-1:0] in_dest,
  input  logic [N_PORTS-1:0]   in_tail,
  output logic [N_PORTS-1:0]   in_grant,
  input  logic [N_PORTS-1:0]   out_ready,
  output logic [N_PORTS-1:0]   out_valid,
  output logic [SEL_W-1:0]     sel_l,
  output logic [SEL_W-1:0]     sel_n,
  output logic [SEL_W-1:0]     sel_e,
  output logic [SEL_W-1:0]     sel_s,
  output logic [SEL_W-1:0]     sel_w
);

  import noc_pkg::*;

  alloc_state_e                     state_q [N_PORTS];
  alloc_state_e                     state_d [N_PORTS];
  logic [N_PORTS-1:0][2:0]          owner_q, owner_d;
  logic [N_PORTS-1:0][2:0]          ptr_q, ptr_d;

  logic [N_PORTS-1:0]               busy;
  logic [N_PORTS-1:0][N_PORTS-1:0]  req;
  logic [N_PORTS-1:0][2:0]          gnt_idx;
  logic [N_PORTS-1:0]               any_gnt;
  logic [N_PORTS-1:0][SEL_W-1:0]    sel_v;

  // Padded copies so a 3-bit owner index always lands in range.
  logic [7:0] vld_x, tail_x, gnt_x;

  assign vld_x  = {{(8-N_PORTS){1'b0}}, in_valid};
  assign tail_x = {{(8-N_PORTS){1'b0}}, in_tail};

  // An input that already holds a locked output may not compete elsewhere;
  // requests are formed per output from each input's decoded destination.
  always_comb begin
    busy = '0;
    req  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (state_q[o] == ST_LOCKED && owner_q[o] == 3'(i)) busy[i] = 1'b1;
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        req[o][i] = in_valid[i] && (in_dest[3*i +: 3] == 3'(o)) && !busy[i];
      end
    end
  end

  // One arbiter per output port.
  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req     (req[o]),
      .ptr     (ptr_q[o]),
      .gnt_idx (gnt_idx[o]),
      .any_gnt (any_gnt[o])
    );
  end

  // Per-output FSM next state plus crossbar select, output valid and input grants.
  always_comb begin
    gnt_x     = '0;
    out_valid = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o] = state_q[o];
      sel_v[o]   = SEL_IDLE;
      case (state_q[o])
        ST_IDLE: begin
          if (any_gnt[o]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = gnt_idx[o];
          end
        end
        ST_LOCKED: begin
          sel_v[o]     = owner_q[o];
          out_valid[o] = vld_x[owner_q[o]];
          if (vld_x[owner_q[o]] && out_ready[o]) begin
            gnt_x[owner_q[o]] = 1'b1;
            if (tail_x[owner_q[o]]) begin
              state_d[o] = ST_IDLE;
              ptr_d[o]   = wrap_inc(owner_q[o]);
            end
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
    end
  end

  assign in_grant = gnt_x[N_PORTS-1:0];

  assign sel_l = sel_v[PORT_L];
  assign sel_n = sel_v[PORT_N];
  assign sel_e = sel_v[PORT_E];
  assign sel_s = sel_v[PORT_S];
  assign sel_w = sel_v[PORT_W];

  // Allocation state; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_PORTS; o++) state_q[o] <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      for (int o = 0; o < N_PORTS; o++) state_q[o] <= state_d[o];
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with hand-computed expectations.
module tb_switch_allocator;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid;
  logic [14:0] in_dest;
  logic [4:0]  in_tail;
  logic [4:0]  in_grant;
  logic [4:0]  out_ready;
  logic [4:0]  out_valid;
  logic [2:0]  sel_l, sel_n, sel_e, sel_s, sel_w;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_tail   (in_tail),
    .in_grant  (in_grant),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel_l     (sel_l),
    .sel_n     (sel_n),
    .sel_e     (sel_e),
    .sel_s     (sel_s),
    .sel_w     (sel_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Step to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic v, input logic [2:0] d, input logic t);
    in_valid[i]      = v;
    in_dest[3*i +: 3] = d;
    in_tail[i]       = t;
  endtask

  task automatic clr();
    in_valid  = '0;
    in_tail   = '0;
    in_dest   = '0;
    out_ready = '1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("rst sels", {sel_l, sel_n, sel_e, sel_s, sel_w}, 15'h7fff);
    chk("rst grant", in_grant, 5'b0);
    chk("rst out_valid", out_valid, 5'b0);
    #10 rst_n = 1'b1;

    // Single 3-flit packet L -> E
    nxt();
    set_pkt(0, 1'b1, PORT_E, 1'b0);
    #2;
    chk("t2 alloc sel_e", sel_e, 7);
    chk("t2 alloc grant", in_grant, 5'b00000);
    nxt(); #2;
    chk("t2 f1 sel_e", sel_e, 0);
    chk("t2 f1 grant", in_grant, 5'b00001);
    chk("t2 f1 out_valid", out_valid, 5'b00100);
    nxt(); #2;
    chk("t2 f2 grant", in_grant, 5'b00001);
    nxt();
    set_pkt(0, 1'b1, PORT_E, 1'b1);
    #2;
    chk("t2 tail grant", in_grant, 5'b00001);
    nxt();
    set_pkt(0, 1'b0, PORT_E, 1'b0);
    #2;
    chk("t2 free sel_e", sel_e, 7);
    chk("t2 free grant", in_grant, 5'b00000);

    // Contention N,S,W -> L, single-flit packets
    nxt();
    set_pkt(1, 1'b1, PORT_L, 1'b1);
    set_pkt(3, 1'b1, PORT_L, 1'b1);
    set_pkt(4, 1'b1, PORT_L, 1'b1);
    #2;
    chk("t3 c0 sel_l", sel_l, 7);
    nxt(); #2;
    chk("t3 c1 sel_l", sel_l, 1);
    chk("t3 c1 grant", in_grant, 5'b00010);
    nxt();
    in_valid[1] = 1'b0;
    #2;
    chk("t3 c2 sel_l", sel_l, 7);
    nxt(); #2;
    chk("t3 c3 sel_l", sel_l, 3);
    chk("t3 c3 grant", in_grant, 5'b01000);
    nxt();
    in_valid[3] = 1'b0;
    #2;
    chk("t3 c4 sel_l", sel_l, 7);
    nxt(); #2;
    chk("t3 c5 sel_l", sel_l, 4);
    chk("t3 c5 grant", in_grant, 5'b10000);
    nxt();
    in_valid[4] = 1'b0;
    #2;
    chk("t3 c6 sel_l", sel_l, 7);

    // Backpressure W -> N
    nxt();
    clr();
    out_ready[1] = 1'b0;
    set_pkt(4, 1'b1, PORT_N, 1'b0);
    #2;
    chk("t4 alloc sel_n", sel_n, 7);
    nxt(); #2;
    chk("t4 s1 sel_n", sel_n, 4);
    chk("t4 s1 grant", in_grant, 5'b00000);
    chk("t4 s1 out_valid", out_valid, 5'b00010);
    nxt(); #2;
    chk("t4 s2 sel_n", sel_n, 4);
    chk("t4 s2 grant", in_grant, 5'b00000);
    nxt();
    in_valid[4] = 1'b0;
    #2;
    chk("t4 s3 sel_n", sel_n, 4);
    chk("t4 s3 out_valid", out_valid, 5'b00000);
    nxt();
    in_valid[4] = 1'b1;
    #2;
    chk("t4 s4 grant", in_grant, 5'b00000);
    nxt();
    out_ready[1] = 1'b1;
    in_tail[4]   = 1'b1;
    #2;
    chk("t4 go grant", in_grant, 5'b10000);
    chk("t4 go out_valid", out_valid, 5'b00010);
    nxt();
    clr();
    #2;
    chk("t4 free sel_n", sel_n, 7);

    // Parallel L -> E and E -> L
    nxt();
    set_pkt(0, 1'b1, PORT_E, 1'b0);
    set_pkt(2, 1'b1, PORT_L, 1'b0);
    #2;
    chk("t5 alloc sels", {sel_e, sel_l}, 6'o77);
    nxt(); #2;
    chk("t5 f1 sel_e", sel_e, 0);
    chk("t5 f1 sel_l", sel_l, 2);
    chk("t5 f1 grant", in_grant, 5'b00101);
    chk("t5 f1 out_valid", out_valid, 5'b00101);
    nxt();
    in_tail[0] = 1'b1;
    in_tail[2] = 1'b1;
    #2;
    chk("t5 tail grant", in_grant, 5'b00101);
    nxt();
    clr();
    #2;
    chk("t5 free sels", {sel_e, sel_l}, 6'o77);
    chk("t5 free grant", in_grant, 5'b00000);

    // Invalid dest 5 on N, U-turn E -> E
    nxt();
    set_pkt(1, 1'b1, 3'd5, 1'b0);
    set_pkt(2, 1'b1, PORT_E, 1'b1);
    #2;
    chk("t6 alloc grant", in_grant, 5'b00000);
    nxt(); #2;
    chk("t6 sel_e", sel_e, 2);
    chk("t6 grant", in_grant, 5'b00100);
    chk("t6 other sels", {sel_l, sel_n, sel_s, sel_w}, 12'hfff);
    nxt();
    in_valid[2] = 1'b0;
    #2;
    chk("t6 free sel_e", sel_e, 7);
    chk("t6 N never", in_grant, 5'b00000);
    nxt(); #2;
    chk("t6 N never 2", {in_grant, out_valid}, 10'b0);

    // Async reset mid-packet W -> E, then re-arbitration from ptr 0
    nxt();
    in_valid[1] = 1'b0;
    set_pkt(4, 1'b1, PORT_E, 1'b0);
    #2;
    nxt(); #2;
    chk("t1 locked sel_e", sel_e, 4);
    chk("t1 locked grant", in_grant, 5'b10000);
    nxt(); #2;
    chk("t1 mid grant", in_grant, 5'b10000);
    #1 rst_n = 1'b0;
    #1;
    chk("t1 async sel_e", sel_e, 7);
    chk("t1 async grant", in_grant, 5'b00000);
    chk("t1 async out_valid", out_valid, 5'b00000);
    nxt();
    rst_n = 1'b1;
    in_valid[4] = 1'b0;
    set_pkt(1, 1'b1, PORT_E, 1'b1);
    set_pkt(3, 1'b1, PORT_E, 1'b1);
    #2;
    chk("t1 post alloc sel_e", sel_e, 7);
    nxt(); #2;
    chk("t1 post sel_e", sel_e, 1);
    chk("t1 post grant", in_grant, 5'b00010);
    nxt();
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
